// File: rtl/sha256_stream_ctrl.sv
// Streams 32-bit message words into a register-mapped sha256 core and returns
// the finished digest; this block is the core's only bus master.
module sha256_stream_ctrl #(
    parameter int TIMEOUT = 1023,
    parameter int SETTLE  = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    input  logic         s_last,
    input  logic         s_mode,
    output logic         cs,
    output logic         we,
    output logic [7:0]   address,
    output logic [31:0]  write_data,
    input  logic [31:0]  read_data,
    output logic         d_valid,
    input  logic         d_ready,
    output logic [255:0] d_data,
    output logic         busy,
    output logic         err
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int SW = $clog2(SETTLE + 2);

    localparam logic [7:0] A_CTRL   = 8'h08;
    localparam logic [7:0] A_STATUS = 8'h09;
    localparam logic [7:0] A_DIG0   = 8'h20;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CTRL, S_SETTLE, S_POLL, S_RDIG, S_OUT
    } state_t;

    state_t         r_state;
    logic           r_s_ready;
    logic           r_cs;
    logic           r_we;
    logic [7:0]     r_addr;
    logic [31:0]    r_wdata;
    logic           r_dvalid;
    logic [255:0]   r_dig;
    logic           r_err;
    logic           r_mode;
    logic           r_first;
    logic           r_last;
    logic [3:0]     r_wcnt;
    logic [2:0]     r_ridx;
    logic [SW-1:0]  r_scnt;
    logic [TW-1:0]  r_tcnt;
    logic           w_hs;

    assign w_hs       = s_valid && r_s_ready;
    assign s_ready    = r_s_ready;
    assign cs         = r_cs;
    assign we         = r_we;
    assign address    = r_addr;
    assign write_data = r_wdata;
    assign d_valid    = r_dvalid;
    assign d_data     = r_dig;
    assign err        = r_err;
    assign busy       = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_s_ready <= 1'b0;
            r_cs      <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= 8'h00;
            r_wdata   <= 32'h0;
            r_dvalid  <= 1'b0;
            r_dig     <= '0;
            r_err     <= 1'b0;
            r_mode    <= 1'b0;
            r_first   <= 1'b0;
            r_last    <= 1'b0;
            r_wcnt    <= 4'h0;
            r_ridx    <= 3'h0;
            r_scnt    <= '0;
            r_tcnt    <= '0;
        end else begin
            // Strobes are single-cycle unless a state explicitly re-asserts them.
            r_cs <= 1'b0;
            r_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_s_ready <= 1'b1;
                    if (w_hs) begin
                        r_mode  <= s_mode;
                        r_first <= 1'b1;
                        r_err   <= 1'b0;
                        r_cs    <= 1'b1;
                        r_we    <= 1'b1;
                        r_addr  <= 8'h10;
                        r_wdata <= s_data;
                        r_wcnt  <= 4'd1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_hs) begin
                        r_cs    <= 1'b1;
                        r_we    <= 1'b1;
                        r_addr  <= {4'h1, r_wcnt};
                        r_wdata <= s_data;
                        r_wcnt  <= r_wcnt + 4'd1;
                        if (r_wcnt == 4'hf) begin
                            r_last    <= s_last;
                            r_s_ready <= 1'b0;
                            r_state   <= S_CTRL;
                        end
                    end
                end
                S_CTRL: begin
                    r_cs    <= 1'b1;
                    r_we    <= 1'b1;
                    r_addr  <= A_CTRL;
                    r_wdata <= {29'h0, r_mode, ~r_first, r_first};
                    r_first <= 1'b0;
                    r_scnt  <= SW'(SETTLE);
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    r_tcnt <= '0;
                    // Last settle cycle pre-loads the status read for the first poll.
                    if (r_scnt == '0) begin
                        r_cs    <= 1'b1;
                        r_addr  <= A_STATUS;
                        r_state <= S_POLL;
                    end else begin
                        r_scnt <= r_scnt - SW'(1);
                    end
                end
                S_POLL: begin
                    if (read_data[0]) begin
                        if (r_last) begin
                            r_cs    <= 1'b1;
                            r_addr  <= A_DIG0;
                            r_ridx  <= 3'd0;
                            r_state <= S_RDIG;
                        end else begin
                            r_wcnt    <= 4'd0;
                            r_s_ready <= 1'b1;
                            r_state   <= S_LOAD;
                        end
                    end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                        r_err     <= 1'b1;
                        r_s_ready <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                        r_cs   <= 1'b1;
                        r_addr <= A_STATUS;
                    end
                end
                S_RDIG: begin
                    // DIGEST0 is read first and ends up in the top word after 8 shifts.
                    r_dig <= {r_dig[223:0], read_data};
                    if (r_ridx == 3'd7) begin
                        r_dvalid <= 1'b1;
                        r_state  <= S_OUT;
                    end else begin
                        r_ridx <= r_ridx + 3'd1;
                        r_cs   <= 1'b1;
                        r_addr <= {5'b00100, r_ridx + 3'd1};
                    end
                end
                S_OUT: begin
                    if (d_ready) begin
                        r_dvalid  <= 1'b0;
                        r_s_ready <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/sha256_stream_ctrl.md
# sha256_stream_ctrl

Sequencer that feeds a 32-bit message-word stream into the `sha256` register-mapped core and returns the finished 256-bit digest on a handshake port. It acts as the core's only bus master: it writes the 16 block words, issues the init/next control write, polls status, and reads back the digest. It sits between the V2X HSM message DMA and the `sha256` instance, so firmware does not have to do per-word register accesses.

## Interface
- `TIMEOUT`, default 1023: maximum poll cycles waiting for core ready before aborting. Minimum 1.
- `SETTLE`, default 3: guard cycles after the CTRL write before status polling starts. Covers core ready de-assertion latency.

- `clk` in 1: single clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `s_valid` in 1: message word valid.
- `s_ready` out 1: message word accepted when `s_valid && s_ready`.
- `s_data` in 32: message word, big-endian block order; word 0 maps to address 0x10.
- `s_last` in 1: sampled with word 15 of a block; 1 = final block of the message.
- `s_mode` in 1: sampled with word 0 of the first block; 1 = SHA-256, 0 = SHA-224.
- `cs`, `we` out 1 each: core bus strobes; registered.
- `address` out 8: core register address; registered.
- `write_data` out 32: core write data; registered.
- `read_data` in 32: core combinational read data.
- `d_valid` out 1: digest valid; held until `d_ready`.
- `d_ready` in 1: digest consumer ready.
- `d_data` out 256: digest; DIGEST0 in [255:224].
- `busy` out 1: high in every state except IDLE.
- `err` out 1: sticky timeout flag; cleared on the first accepted word of the next message.

## Operation
- States: IDLE, LOAD, CTRL, SETTLE, POLL, RDIG, OUT.
- IDLE:
  - `s_ready`=1.
  - On handshake: latch `s_mode`, set `first`=1, clear `err`.
  - Issue the word write, set `wcnt`=1, go to LOAD.
- LOAD:
  - `s_ready`=1.
  - Each handshake registers a bus write next cycle: `cs`=1, `we`=1, `address`=0x10+`wcnt`, `write_data`=`s_data`. Then `wcnt`++ (4-bit, wraps).
  - Word 15 handshake latches `s_last`, then go to CTRL.
  - Cycles with no handshake drive `cs`=0.
- CTRL:
  - One cycle, `s_ready`=0.
  - Write to address 0x08 with data {29'h0, mode, ~`first`, `first`}: init on the first block, next on later blocks.
  - Clear `first`, load the settle counter, go to SETTLE.
- SETTLE:
  - `cs`=0 for `SETTLE` cycles, then go to POLL.
  - Clear the timeout counter.
- POLL:
  - Drive `cs`=1, `we`=0, `address`=0x09 every cycle. Sample `read_data[0]` in the same cycle.
  - Ready=1: if last, go to RDIG with index 0; else go to LOAD with `wcnt`=0.
  - Ready=0: increment the timeout counter. Reaching `TIMEOUT` sets `err`=1 and goes to IDLE; the digest is discarded and `d_valid` is not raised.
- RDIG:
  - 8 cycles, reading addresses 0x20..0x27.
  - Each cycle shift `read_data` into `d_data` from the top word down.
  - After 0x27, go to OUT.
- OUT:
  - `d_valid`=1, `s_ready`=0.
  - On `d_ready`, go to IDLE; `d_data` holds its value.
- SHA-224: all 8 words are still read; the consumer uses [255:32].
- Sync reset at any time:
  - State returns to IDLE, all counters cleared.
  - The core is not reset by this block. Any in-flight core operation is abandoned; the next message re-inits.

## Timing
- Reset values: `s_ready`=0 in the reset cycle and 1 from the first IDLE cycle. `cs`=`we`=0, `address`=0, `write_data`=0, `d_valid`=0, `d_data`=0, `busy`=0, `err`=0.
- Load throughput is 1 word/cycle. The bus write lags its handshake by 1 cycle.
- Word 15 handshake at cycle T:
  - T+1: word 15 write.
  - T+2: CTRL write.
  - T+3..T+2+`SETTLE`: settle.
  - T+3+`SETTLE`: first poll.
- Ready seen at poll cycle P: reads at P+1..P+8, `d_valid` high from P+9.
- `s_last`/`s_mode` are ignored on words other than 15 and the first word.
- `d_valid`&&`d_ready` in the same cycle completes the transfer; IDLE follows in the next cycle.

## Test plan
- Single block "abc", SHA-256: words 61626380, 0×14, 00000018, `s_last`=1 → `d_data`=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; CTRL write data = 0x5.
- Same block with `s_mode`=0 → `d_data`[255:32]=23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7; CTRL data = 0x1.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" → CTRL data 0x5 then 0x6; digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Random `s_valid` gaps and `d_ready` held low for 20 cycles → digest unchanged, `d_valid` stays high, no extra bus writes.
- Core stub with status fixed at 0, `TIMEOUT`=16 → `err`=1 exactly 16 poll cycles after the first poll, no `d_valid`; next message's first word clears `err`.
- `reset_n`=0 for 1 cycle mid-LOAD (word 7) → IDLE next cycle with all outputs at reset values; a following full "abc" message still yields the correct digest.
